// File: rtl/sine_wave_analyser.sv
// Tone monitor: tracks rising mid-level crossings of an unsigned sample stream with hysteresis,
// measures period/peak/trough/amplitude per cycle of the waveform and flags lock on a stable period.
module sine_wave_analyser #(
   parameter int SINE_SIZE  = 12,
   parameter int COUNT_W    = 16,
   parameter int MID        = 2048,
   parameter int HYST       = 64,
   parameter int MAX_PERIOD = 4095,
   parameter int TOL        = 2,
   parameter int LOCK_COUNT = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [SINE_SIZE-1:0] sample,
   input  logic                 sample_valid,
   output logic [COUNT_W-1:0]   period,
   output logic [SINE_SIZE-1:0] peak,
   output logic [SINE_SIZE-1:0] trough,
   output logic [SINE_SIZE-1:0] amplitude,
   output logic                 meas_valid,
   output logic                 crossing,
   output logic                 timeout,
   output logic                 locked
);

   localparam int                      MATCH_W   = $clog2(LOCK_COUNT + 1);
   localparam int                      DIFF_W    = COUNT_W + 1;
   localparam logic [SINE_SIZE-1:0]    HI_LEVEL  = SINE_SIZE'(MID + HYST);
   localparam logic [SINE_SIZE-1:0]    LO_LEVEL  = SINE_SIZE'(MID - HYST);
   localparam logic [COUNT_W-1:0]      CNT_MAX   = COUNT_W'(MAX_PERIOD);
   localparam logic [MATCH_W-1:0]      MATCH_MAX = MATCH_W'(LOCK_COUNT);
   localparam logic signed [DIFF_W-1:0] TOL_S    = DIFF_W'(TOL);

   typedef enum logic {SEEK, MEASURE} state_t;

   state_t                     state_q, state_d;
   logic                       hi, hi_next, rise, at_limit;
   logic                       start, measure, step, expire;
   logic [COUNT_W-1:0]         cnt, prev_period;
   logic [SINE_SIZE-1:0]       acc_peak, acc_trough;
   logic                       prev_ok;
   logic [MATCH_W-1:0]         match_cnt, match_next;
   logic signed [DIFF_W-1:0]   diff, diff_abs;

   // NOTE: every variable driven from always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      hi_next = hi;
      if (sample >= HI_LEVEL)      hi_next = 1'b1;
      else if (sample <= LO_LEVEL) hi_next = 1'b0;
   end

   assign rise     = sample_valid & ~hi & hi_next;
   assign at_limit = (cnt == CNT_MAX);

   // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state_q <= SEEK;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (sample_valid) begin
         case (state_q)
            SEEK:    if (rise) state_d = MEASURE;
            MEASURE: if (!rise && at_limit) state_d = SEEK;
            default: state_d = SEEK;
         endcase
      end
   end

   always_comb begin
      start   = 1'b0;
      measure = 1'b0;
      step    = 1'b0;
      expire  = 1'b0;
      if (sample_valid) begin
         case (state_q)
            SEEK: start = rise;
            MEASURE: begin
               measure = rise;
               step    = !rise && !at_limit;
               expire  = !rise && at_limit;
            end
            default: ;
         endcase
      end
   end

   // Tolerance check on the closing period against the previous one, saturating at LOCK_COUNT.
   assign diff     = $signed({1'b0, cnt}) - $signed({1'b0, prev_period});
   assign diff_abs = diff[DIFF_W-1] ? -diff : diff;

   always_comb begin
      match_next = '0;
      if (prev_ok && (diff_abs <= TOL_S))
         match_next = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi          <= 1'b1;
         cnt         <= '0;
         acc_peak    <= '0;
         acc_trough  <= '0;
         prev_period <= '0;
         prev_ok     <= 1'b0;
         match_cnt   <= '0;
         period      <= '0;
         peak        <= '0;
         trough      <= '0;
         amplitude   <= '0;
         meas_valid  <= 1'b0;
         crossing    <= 1'b0;
         timeout     <= 1'b0;
         locked      <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         crossing   <= 1'b0;
         timeout    <= 1'b0;
         if (sample_valid) begin
            hi       <= hi_next;
            crossing <= rise;
         end
         if (start || measure) begin
            cnt        <= COUNT_W'(1);
            acc_peak   <= sample;
            acc_trough <= sample;
         end
         if (start) prev_ok <= 1'b0;
         if (step) begin
            cnt <= cnt + COUNT_W'(1);
            if (sample > acc_peak)   acc_peak   <= sample;
            if (sample < acc_trough) acc_trough <= sample;
         end
         if (measure) begin
            period      <= cnt;
            peak        <= acc_peak;
            trough      <= acc_trough;
            amplitude   <= (acc_peak - acc_trough) >> 1;
            meas_valid  <= 1'b1;
            match_cnt   <= match_next;
            locked      <= (match_next == MATCH_MAX);
            prev_period <= cnt;
            prev_ok     <= 1'b1;
         end
         // A timeout abandons the partial period but keeps the last reported measurement.
         if (expire) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
            prev_ok   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sine_wave_analyser.sv
// Randomised and directed bench for sine_wave_analyser against a sample-history model:
// each period is kept as a queue of samples and lock is judged from the recent period history.
module tb_sine_wave_analyser;

   localparam int SINE_SIZE  = 12;
   localparam int COUNT_W    = 16;
   localparam int MID        = 2048;
   localparam int HYST       = 64;
   localparam int MAX_PERIOD = 4095;
   localparam int TOL        = 2;
   localparam int LOCK_COUNT = 3;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic [SINE_SIZE-1:0] sample = '0;
   logic                 sample_valid = 1'b0;
   logic [COUNT_W-1:0]   period;
   logic [SINE_SIZE-1:0] peak, trough, amplitude;
   logic                 meas_valid, crossing, timeout, locked;

   always #5 clock = ~clock;

   sine_wave_analyser #(
      .SINE_SIZE(SINE_SIZE), .COUNT_W(COUNT_W), .MID(MID), .HYST(HYST),
      .MAX_PERIOD(MAX_PERIOD), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)
   ) dut (
      .clock(clock), .reset(reset), .sample(sample), .sample_valid(sample_valid),
      .period(period), .peak(peak), .trough(trough), .amplitude(amplitude),
      .meas_valid(meas_valid), .crossing(crossing), .timeout(timeout), .locked(locked)
   );

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   // Model state: hysteresis flag, whether a period is open, its samples, and recent periods.
   bit m_hi = 1'b1;
   bit m_meas = 1'b0;
   int cur[$];
   int hist[$];
   int e_period = 0, e_peak = 0, e_trough = 0, e_amp = 0;
   bit e_mv = 0, e_cross = 0, e_to = 0, e_locked = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit lock_from_history();
      int n = hist.size();
      if (n < LOCK_COUNT + 1) return 1'b0;
      for (int i = 0; i < LOCK_COUNT; i++) begin
         int d = hist[n-1-i] - hist[n-2-i];
         if (d < 0) d = -d;
         if (d > TOL) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step(input bit r, input bit v, input int s);
      bit new_hi, rise;
      int mx, mn;
      e_mv = 0; e_cross = 0; e_to = 0;
      if (r) begin
         m_hi = 1; m_meas = 0; cur.delete(); hist.delete();
         e_period = 0; e_peak = 0; e_trough = 0; e_amp = 0; e_locked = 0;
         return;
      end
      if (!v) return;
      new_hi = (s >= MID + HYST) ? 1'b1 : (s <= MID - HYST) ? 1'b0 : m_hi;
      rise = !m_hi && new_hi;
      m_hi = new_hi;
      e_cross = rise;
      if (!m_meas) begin
         if (rise) begin
            m_meas = 1; cur.delete(); cur.push_back(s); hist.delete();
         end
      end else if (rise) begin
         mx = cur[0]; mn = cur[0];
         foreach (cur[i]) begin
            if (cur[i] > mx) mx = cur[i];
            if (cur[i] < mn) mn = cur[i];
         end
         e_period = cur.size(); e_peak = mx; e_trough = mn; e_amp = (mx - mn) / 2; e_mv = 1;
         hist.push_back(cur.size());
         if (hist.size() > LOCK_COUNT + 1) void'(hist.pop_front());
         e_locked = lock_from_history();
         cur.delete(); cur.push_back(s);
      end else if (cur.size() == MAX_PERIOD) begin
         m_meas = 0; e_to = 1; e_locked = 0; cur.delete(); hist.delete();
      end else begin
         cur.push_back(s);
      end
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         n_vec++;
         check("period", 32'(period), e_period);
         check("peak", 32'(peak), e_peak);
         check("trough", 32'(trough), e_trough);
         check("amplitude", 32'(amplitude), e_amp);
         check("meas_valid", 32'(meas_valid), 32'(e_mv));
         check("crossing", 32'(crossing), 32'(e_cross));
         check("timeout", 32'(timeout), 32'(e_to));
         check("locked", 32'(locked), 32'(e_locked));
      end
   end

   task automatic apply(input bit r, input bit v, input int s);
      @(negedge clock);
      reset = r; sample_valid = v; sample = SINE_SIZE'(s);
      @(posedge clock);
      model_step(r, v, s);
      #1;
   endtask

   initial begin
      int mv, pulses, to_cnt, cr;

      apply(1, 0, 0);
      cmp_en = 1'b1;
      apply(1, 1, 4095);
      check("lit_rst_period", 32'(period), 0);
      check("lit_rst_locked", 32'(locked), 0);

      // Samples inside the hysteresis band never qualify.
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         apply(0, 1, (i % 2) ? 2100 : 2000);
         pulses += int'(crossing) + int'(meas_valid) + int'(timeout);
      end
      check("lit_band_pulses", pulses, 0);

      // Period-8 square wave: lock on the 4th measurement.
      mv = 0;
      for (int b = 0; b < 6; b++)
         for (int t = 0; t < 8; t++) begin
            apply(0, 1, (t < 4) ? 0 : 4095);
            if (meas_valid) begin
               mv++;
               if (mv == 1) begin
                  check("lit_p8_period", 32'(period), 8);
                  check("lit_p8_peak", 32'(peak), 4095);
                  check("lit_p8_trough", 32'(trough), 0);
                  check("lit_p8_amp", 32'(amplitude), 2047);
               end
               if (mv == 3) check("lit_p8_unlocked3", 32'(locked), 0);
               if (mv == 4) check("lit_p8_locked4", 32'(locked), 1);
            end
         end
      check("lit_p8_meas_count", mv, 5);

      // Same sequence with an idle cycle before every sample.
      mv = 0;
      for (int b = 0; b < 3; b++)
         for (int t = 0; t < 8; t++) begin
            apply(0, 0, int'($urandom_range(0, 4095)));
            apply(0, 1, (t < 4) ? 0 : 4095);
            if (meas_valid) begin
               mv++;
               check("lit_gap_period", 32'(period), 8);
               check("lit_gap_locked", 32'(locked), 1);
            end
         end
      check("lit_gap_meas_count", mv, 3);

      // Switch to period 12; the boundary period is also 12.
      apply(0, 1, 4095);
      apply(0, 1, 4095);
      mv = 0;
      for (int b = 0; b < 5; b++)
         for (int t = 0; t < 12; t++) begin
            apply(0, 1, (t < 6) ? 0 : 4095);
            if (meas_valid) begin
               mv++;
               if (mv == 1) begin
                  check("lit_p12_period", 32'(period), 12);
                  check("lit_p12_drop", 32'(locked), 0);
               end
               if (mv == 3) check("lit_p12_unlocked3", 32'(locked), 0);
               if (mv == 4) check("lit_p12_relock", 32'(locked), 1);
            end
         end

      // One rise followed by a held high level: timeout on the 4096th high sample.
      for (int t = 0; t < 6; t++) apply(0, 1, 0);
      to_cnt = 0; mv = 0;
      for (int i = 0; i < 4096; i++) begin
         apply(0, 1, 4095);
         to_cnt += int'(timeout);
         if (i > 0) mv += int'(meas_valid);
         if (i == 4094) check("lit_to_not_early", 32'(timeout), 0);
         if (i == 4095) check("lit_to_pulse", 32'(timeout), 1);
      end
      check("lit_to_count", to_cnt, 1);
      check("lit_to_no_meas", mv, 0);
      check("lit_to_held_period", 32'(period), 12);
      check("lit_to_unlocked", 32'(locked), 0);

      // Reset in mid-period, then a high level alone must not qualify.
      for (int b = 0; b < 2; b++)
         for (int t = 0; t < 8; t++) apply(0, 1, (t < 4) ? 0 : 4095);
      apply(0, 1, 0);
      apply(0, 1, 0);
      apply(1, 1, 0);
      check("lit_mid_rst_period", 32'(period), 0);
      check("lit_mid_rst_peak", 32'(peak), 0);
      check("lit_mid_rst_amp", 32'(amplitude), 0);
      cr = 0;
      for (int i = 0; i < 10; i++) begin
         apply(0, 1, 4095);
         cr += int'(crossing);
      end
      check("lit_mid_rst_no_cross", cr, 0);
      apply(0, 1, 0);
      apply(0, 1, 4095);
      check("lit_mid_rst_cross", 32'(crossing), 1);

      // Random square-ish waves with random level jitter and random valid gaps.
      for (int run = 0; run < 12; run++) begin
         int p    = int'($urandom_range(5, 30));
         int hi_v = int'($urandom_range(2113, 4095));
         int lo_v = int'($urandom_range(0, 1983));
         for (int k = 0; k < 7 * p; k++) begin
            int s = ((k % p) < p / 2) ? lo_v - int'($urandom_range(0, 20))
                                      : hi_v - int'($urandom_range(0, 40));
            if (s < 0) s = 0;
            apply(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), s);
         end
      end
      for (int i = 0; i < 400; i++)
         apply(0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)));

      @(negedge clock);
      @(negedge clock);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
